// File: rtl/nn_pkg.sv
// Shared fixed-point helpers, FSM state encoding and default widths for the MAC array.
package nn_pkg;

  localparam int unsigned NN_DATA_W = 16;
  localparam int unsigned NN_FRAC_W = 8;
  localparam int unsigned NN_ACC_W  = 40;

  // Working width for saturation arithmetic; must exceed ACC_W + 1.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT
  } nn_state_e;

  // Fixed-point saturation test against a w-bit signed range.
  // Returns {over, under}; the caller substitutes its own limits so no
  // oversized intermediate has to be carried around.
  function automatic logic [1:0] fx_sat_flags(input logic signed [SAT_W-1:0] x,
                                              input int unsigned             w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return {(x > hi), (x < lo)};
  endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One MAC lane: registered product, saturating accumulator, output conversion.
module nn_mac_lane
  import nn_pkg::*;
#(
  parameter int unsigned DATA_W = NN_DATA_W,
  parameter int unsigned FRAC_W = NN_FRAC_W,
  parameter int unsigned ACC_W  = NN_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     load,
  input  logic                     beat,
  input  logic                     chk,
  input  logic                     relu_en,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] act,
  input  logic signed [DATA_W-1:0] wgt,
  output logic        [DATA_W-1:0] res,
  output logic                     ovf
);

  localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic        [DATA_W-1:0] DAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic        [DATA_W-1:0] DAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       ovf_q, ovf_d;

  logic signed [SAT_W-1:0]    sum_w;
  logic signed [SAT_W-1:0]    shr_w;
  logic        [1:0]          acc_fl;
  logic        [1:0]          out_fl;
  logic signed [ACC_W-1:0]    acc_sum;
  logic        [DATA_W-1:0]   conv;

  // Product stage: only accepted beats load a product, otherwise zero so idle adds are no-ops.
  always_comb begin
    prod_d = '0;
    if (!clr && beat) begin
      prod_d = (2*DATA_W)'(act) * (2*DATA_W)'(wgt);
    end
  end

  // Saturating sum of accumulator and registered product.
  always_comb begin
    sum_w  = SAT_W'(acc_q) + SAT_W'(prod_q);
    acc_fl = fx_sat_flags(sum_w, ACC_W);
    if (acc_fl[1])      acc_sum = ACC_MAX;
    else if (acc_fl[0]) acc_sum = ACC_MIN;
    else                acc_sum = sum_w[ACC_W-1:0];
  end

  // Output conversion: drop fraction, clip to DATA_W, then optional ReLU.
  always_comb begin
    shr_w  = SAT_W'(acc_q) >>> FRAC_W;
    out_fl = fx_sat_flags(shr_w, DATA_W);
    if (out_fl[1])      conv = DAT_MAX;
    else if (out_fl[0]) conv = DAT_MIN;
    else                conv = shr_w[DATA_W-1:0];
    if (relu_en && conv[DATA_W-1]) conv = '0;
  end

  // Accumulator and sticky overflow next-state; clear keeps ovf, job load resets it.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = ACC_W'(bias) <<< FRAC_W;
      ovf_d = 1'b0;
    end else begin
      acc_d = acc_sum;
      ovf_d = ovf_q | (|acc_fl) | (chk & (|out_fl));
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign res = conv;
  assign ovf = ovf_q;

endmodule

// File: rtl/nn_mac_array.sv
// Multi-lane fixed-point dot-product engine sharing one activation stream.
module nn_mac_array
  import nn_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = NN_DATA_W,
  parameter int unsigned FRAC_W = NN_FRAC_W,
  parameter int unsigned ACC_W  = NN_ACC_W,
  parameter int unsigned LEN_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    relu_en,
  input  logic [LANES*DATA_W-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_act,
  input  logic [LANES*DATA_W-1:0] in_wgt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        ovf,
  output logic                    busy
);

  nn_state_e        state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             relu_q, relu_d;

  logic lane_clr;
  logic lane_load;
  logic lane_beat;
  logic lane_chk;

  // Job sequencing. DRAIN is a single cycle: the last product is added on the
  // same edge that enters OUT, giving a fixed two-cycle beat-to-result latency.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    relu_d    = relu_q;
    lane_clr  = 1'b0;
    lane_load = 1'b0;
    lane_beat = 1'b0;
    if (clear) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      lane_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d     = len;
            relu_d    = relu_en;
            cnt_d     = '0;
            lane_load = 1'b1;
            state_d   = (len == '0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            lane_beat = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_d == len_q) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: state_d = ST_OUT;
        ST_OUT: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      relu_q  <= relu_d;
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign lane_chk  = (state_q == ST_OUT);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    nn_mac_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (lane_clr),
      .load    (lane_load),
      .beat    (lane_beat),
      .chk     (lane_chk),
      .relu_en (relu_q),
      .bias    (bias[g*DATA_W +: DATA_W]),
      .act     (in_act),
      .wgt     (in_wgt[g*DATA_W +: DATA_W]),
      .res     (out_data[g*DATA_W +: DATA_W]),
      .ovf     (ovf[g])
    );
  end

endmodule

// File: tb/tb_nn_mac_array.sv
// Scoreboard bench for nn_mac_array with a longint reference model.
module tb_nn_mac_array;

  localparam int LN = 4;
  localparam int DW = 16;
  localparam int LW = 10;

  logic              clk = 1'b0;
  logic              rst, clear, start, relu_en, in_valid, out_ready;
  logic [LW-1:0]     len;
  logic [LN*DW-1:0]  bias, in_wgt, out_data;
  logic [DW-1:0]     in_act;
  logic              in_ready, out_valid, busy;
  logic [LN-1:0]     ovf;

  nn_mac_array #(
    .LANES  (LN),
    .DATA_W (DW),
    .FRAC_W (8),
    .ACC_W  (40),
    .LEN_W  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .start     (start),
    .len       (len),
    .relu_en   (relu_en),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [LN*DW-1:0] data;
    logic [LN-1:0]    ovf;
  } exp_t;

  exp_t sbq[$];

  // Reference model state: real-valued accumulators scaled by 2^8.
  longint acc_m[LN];
  logic [LN-1:0] ovf_m;
  logic relu_m;
  localparam longint AMAX = (longint'(1) <<< 39) - 1;
  localparam longint AMIN = -(longint'(1) <<< 39);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start(input logic [LN*DW-1:0] b, input logic r);
    for (int i = 0; i < LN; i++) begin
      logic signed [DW-1:0] bi;
      bi = b[i*DW +: DW];
      acc_m[i] = longint'(bi) * 256;
    end
    ovf_m  = '0;
    relu_m = r;
  endtask

  task automatic model_beat(input logic [DW-1:0] a, input logic [LN*DW-1:0] w);
    logic signed [DW-1:0] sa;
    sa = a;
    for (int i = 0; i < LN; i++) begin
      logic signed [DW-1:0] sw;
      sw = w[i*DW +: DW];
      acc_m[i] = acc_m[i] + longint'(sa) * longint'(sw);
      if (acc_m[i] > AMAX) begin acc_m[i] = AMAX; ovf_m[i] = 1'b1; end
      if (acc_m[i] < AMIN) begin acc_m[i] = AMIN; ovf_m[i] = 1'b1; end
    end
  endtask

  task automatic model_result(output exp_t e);
    for (int i = 0; i < LN; i++) begin
      longint r;
      r = acc_m[i] / 256;
      if (acc_m[i] < 0 && (acc_m[i] % 256) != 0) r = r - 1;  // floor division
      if (r > 32767)  begin r = 32767;  ovf_m[i] = 1'b1; end
      if (r < -32768) begin r = -32768; ovf_m[i] = 1'b1; end
      if (relu_m && r < 0) r = 0;
      e.data[i*DW +: DW] = r[DW-1:0];
    end
    e.ovf = ovf_m;
  endtask

  function automatic logic [DW-1:0] rnd16();
    if ($urandom_range(0, 1) == 1) return 16'($urandom_range(0, 16'hFFFF));
    return 16'($urandom_range(0, 1023)) - 16'd512;
  endfunction

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", out_data);
        end else begin
          e = sbq.pop_front();
          check("out_data", out_data, e.data);
          @(negedge clk);
          check("ovf_after_out", ovf, e.ovf);
        end
      end
    end
  end

  task automatic run_job(input logic [LW-1:0] n, input logic [LN*DW-1:0] b, input logic r,
                         input int gap_pct, input int stall, input logic fixed,
                         input logic [DW-1:0] fa, input logic [LN*DW-1:0] fw);
    int beats;
    int budget;
    exp_t e;
    start = 1'b1; len = n; bias = b; relu_en = r;
    model_start(b, r);
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ovf_cleared_by_start", ovf, 0);
    beats  = 0;
    budget = 0;
    while (beats < int'(n)) begin
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_act = fixed ? fa : rnd16();
        in_wgt = fixed ? fw : {rnd16(), rnd16(), rnd16(), rnd16()};
      end
      if (in_valid && in_ready) begin
        model_beat(in_act, in_wgt);
        beats++;
      end
      tick();
      budget++;
      if (budget > 500) begin
        in_valid = 1'b0;
        check("in_ready_timeout", 0, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    model_result(e);
    sbq.push_back(e);
    check("out_valid_1cyc", out_valid, 0);
    check("in_ready_drain", in_ready, 0);
    tick();
    check("out_valid_2cyc", out_valid, 1);
    for (int s = 0; s < stall; s++) begin
      check("stall_data", out_data, e.data);
      tick();
      check("stall_valid", out_valid, 1);
    end
    start = 1'b1;      // must be ignored outside IDLE
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    check("busy_after_out", busy, 0);
    tick();
    check("idle_no_restart", busy, 0);
  endtask

  task automatic start_raw(input logic [LW-1:0] n, input logic [LN*DW-1:0] b);
    start = 1'b1; len = n; bias = b; relu_en = 1'b0;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; len = '0; bias = '0; in_act = '0; in_wgt = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ovf", ovf, 0);

    // Basic dot product
    run_job(3, '0, 1'b0, 0, 0, 1'b1, 16'h0100, {4{16'h0200}});
    // Bias with and without ReLU
    run_job(1, {48'h0, 16'hFF00}, 1'b1, 0, 0, 1'b1, 16'h0000, {4{16'h1234}});
    run_job(1, {48'h0, 16'hFF00}, 1'b0, 0, 0, 1'b1, 16'h0000, {4{16'h1234}});
    // Output saturation, then a fresh start clears ovf
    run_job(4, '0, 1'b0, 0, 0, 1'b1, 16'h7F00, {4{16'h7F00}});
    run_job(2, '0, 1'b0, 0, 0, 1'b1, 16'h0100, {4{16'h0100}});
    // Gapped input and stalled output; zero-length job returns bias
    run_job(5, {16'h0100, 16'hFE00, 16'h0040, 16'h8000}, 1'b0, 40, 5, 1'b0, '0, '0);
    run_job(0, {16'h0100, 16'hFE00, 16'h0040, 16'h8000}, 1'b0, 0, 5, 1'b0, '0, '0);

    // Abort with clear after 2 of 4 beats
    start_raw(4, {4{16'h0300}});
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_act = rnd16(); in_wgt = {rnd16(), rnd16(), rnd16(), rnd16()};
      tick();
    end
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_busy", busy, 0);
    check("clear_in_ready", in_ready, 0);
    check("clear_out_data", out_data, 0);

    // Reset mid-run
    start_raw(4, {4{16'h0500}});
    in_valid = 1'b1; in_act = 16'h0100; in_wgt = {4{16'h0100}};
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_ovf", ovf, 0);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      logic [LN*DW-1:0] b;
      b = {rnd16(), rnd16(), rnd16(), rnd16()};
      run_job(LW'($urandom_range(0, 8)), b, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 50)), int'($urandom_range(0, 4)), 1'b0, '0, '0);
    end

    tick();
    check("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
